// File: rtl/phy_tx_multilane.sv
// Multilane transmit PHY: stripes words across serial lanes, with idle fill,
// a post-reset symbol-sync phase and a recirculation path while inactive.
module phy_tx_multilane #(
    parameter int         DATA_W    = 32,
    parameter int         LANES     = 2,
    parameter logic [7:0] IDLE_SYM  = 8'hBC,
    parameter int         INIT_SYMS = 4
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_input,
    input  logic              valid,
    input  logic              active,
    output logic              ready,
    output logic [LANES-1:0]  data_paralelo_serial,
    output logic [DATA_W-1:0] data_recirculador_inactive,
    output logic              valid_recirculador_inactive,
    output logic [1:0]        tx_state
);

    localparam int P   = DATA_W / LANES;
    localparam int BPL = P / 8;
    localparam int CW  = (P > 1) ? $clog2(P) : 1;
    localparam logic [CW-1:0] LAST = CW'(P - 1);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [7:0]        sync_q, sync_d;
    logic [P-1:0]      sr_q [LANES];
    logic [P-1:0]      sr_d [LANES];
    logic [P-1:0]      pay  [LANES];
    logic [P-1:0]      idle_w;
    logic              load;
    logic              use_pay;
    logic [LANES-1:0]  ser_q;
    logic [DATA_W-1:0] rec_data_q;
    logic              rec_valid_q;

    assign idle_w = {BPL{IDLE_SYM}};
    assign load   = (cnt_q == LAST);

    // Lane l carries bytes l, l+LANES, ... with the lowest byte at the MSB end.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            pay[l] = '0;
            for (int j = 0; j < BPL; j++) begin
                pay[l][P-1-8*j -: 8] = data_input[8*(l + LANES*j) +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sync_d  = sync_q;
        use_pay = 1'b0;
        if (load) begin
            unique case (state_q)
                SYNC: begin
                    sync_d = sync_q + 8'd1;
                    if (sync_q == 8'(INIT_SYMS - 1)) begin
                        state_d = active ? ACTIVE : IDLE;
                    end
                end
                IDLE: begin
                    if (active) begin
                        state_d = ACTIVE;
                        use_pay = valid;
                    end
                end
                ACTIVE: begin
                    if (active) begin
                        use_pay = valid;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = SYNC;
            endcase
        end
        for (int l = 0; l < LANES; l++) begin
            if (load) begin
                sr_d[l] = use_pay ? pay[l] : idle_w;
            end else begin
                sr_d[l] = {sr_q[l][P-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            cnt_q       <= '0;
            state_q     <= SYNC;
            sync_q      <= '0;
            ser_q       <= '0;
            rec_data_q  <= '0;
            rec_valid_q <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                sr_q[l] <= '0;
            end
        end else begin
            cnt_q   <= load ? '0 : cnt_q + CW'(1);
            state_q <= state_d;
            sync_q  <= sync_d;
            // Output taken from next-state MSB so a word starts one cycle after its load.
            for (int l = 0; l < LANES; l++) begin
                sr_q[l]  <= sr_d[l];
                ser_q[l] <= sr_d[l][P-1];
            end
            if (state_q != ACTIVE) begin
                rec_data_q  <= valid ? data_input : '0;
                rec_valid_q <= valid;
            end else begin
                rec_data_q  <= '0;
                rec_valid_q <= 1'b0;
            end
        end
    end

    assign ready                       = load && (state_q == ACTIVE);
    assign data_paralelo_serial        = ser_q;
    assign data_recirculador_inactive  = rec_data_q;
    assign valid_recirculador_inactive = rec_valid_q;
    assign tx_state                    = state_q;

endmodule

// File: tb/tb_phy_tx_multilane.sv
// Scoreboard bench for phy_tx_multilane: word-level reference model feeds
// per-cycle expectations to an independent monitor.
module tb_phy_tx_multilane;

    localparam int DW   = 32;
    localparam int LN   = 2;
    localparam int PP   = DW / LN;
    localparam int INIT = 4;

    logic          clk_32f = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data_input = '0;
    logic          valid = 1'b0;
    logic          active = 1'b0;
    logic          ready;
    logic [LN-1:0] data_paralelo_serial;
    logic [DW-1:0] data_recirculador_inactive;
    logic          valid_recirculador_inactive;
    logic [1:0]    tx_state;

    phy_tx_multilane #(
        .DATA_W(DW), .LANES(LN), .IDLE_SYM(8'hBC), .INIT_SYMS(INIT)
    ) dut (
        .clk_32f(clk_32f),
        .reset(reset),
        .data_input(data_input),
        .valid(valid),
        .active(active),
        .ready(ready),
        .data_paralelo_serial(data_paralelo_serial),
        .data_recirculador_inactive(data_recirculador_inactive),
        .valid_recirculador_inactive(valid_recirculador_inactive),
        .tx_state(tx_state)
    );

    always #5 clk_32f = ~clk_32f;

    typedef struct {
        logic [LN-1:0] ser;
        int            st;
        logic          rv;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t          sbq[$];
    logic [LN-1:0] bitq[$];
    int            tests = 0;
    int            fails = 0;
    bit            running = 1'b1;
    bit            m_known = 1'b0;
    int            m_cnt = 0;
    int            m_state = 0;
    int            m_sync = 0;
    bit            m_consumed = 1'b0;
    logic [DW-1:0] idle_word = {4{8'hBC}};

    function automatic void chk(input string nm, input logic [63:0] got,
                                input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endfunction

    // Bit i of the word on lane l: byte l + LN*(i/8), MSB first.
    function automatic logic [LN-1:0] lane_bits(input logic [DW-1:0] w, input int i);
        logic [LN-1:0] r;
        for (int l = 0; l < LN; l++) begin
            r[l] = w[8*(l + LN*(i/8)) + 7 - (i%8)];
        end
        return r;
    endfunction

    task automatic fill(input logic [DW-1:0] w);
        bitq.delete();
        for (int i = 0; i < PP; i++) bitq.push_back(lane_bits(w, i));
    endtask

    task automatic step(input logic rst, input logic act, input logic vld,
                        input logic [DW-1:0] d);
        exp_t e;
        bit   ld;
        bit   pay;
        reset = rst; active = act; valid = vld; data_input = d;
        #1;
        ld = (m_cnt == PP - 1);
        m_consumed = 1'b0;
        if (m_known) chk("ready", ready, ld && m_state == 2);
        if (rst) begin
            m_known = 1'b1;
            m_cnt = 0; m_state = 0; m_sync = 0;
            bitq.delete();
            e.ser = '0; e.st = 0; e.rv = 1'b0; e.rd = '0;
        end else begin
            e.rv = (m_state != 2) && vld;
            e.rd = e.rv ? d : '0;
            if (ld) begin
                pay = 1'b0;
                case (m_state)
                    0: begin
                        m_sync++;
                        if (m_sync == INIT) m_state = act ? 2 : 1;
                    end
                    1: if (act) begin m_state = 2; pay = vld; end
                    default: begin
                        if (!act) m_state = 1;
                        else begin pay = vld; m_consumed = vld; end
                    end
                endcase
                fill(pay ? d : idle_word);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            e.ser = (bitq.size() > 0) ? bitq.pop_front() : '0;
            e.st = m_state;
        end
        sbq.push_back(e);
        @(negedge clk_32f);
    endtask

    task automatic wait_active_load(input logic [DW-1:0] d);
        bit found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_state == 2 && m_cnt == PP - 1) begin found = 1'b1; break; end
            step(1'b0, 1'b1, 1'b0, d);
        end
        chk("reach_active_load", found, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        while (running) begin
            @(posedge clk_32f);
            #1;
            if (!running) break;
            if (sbq.size() == 0) begin
                chk("scoreboard_empty", 1'b0, 1'b1);
            end else begin
                e = sbq.pop_front();
                chk("serial", data_paralelo_serial, e.ser);
                chk("tx_state", tx_state, e.st);
                chk("recirc_valid", valid_recirculador_inactive, e.rv);
                chk("recirc_data", data_recirculador_inactive, e.rd);
            end
        end
    end

    initial begin : driver
        logic [15:0]   cap0, cap1;
        logic [DW-1:0] held;
        bit            act_r;

        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 90; i++) begin
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom);
        end
        chk("idle_after_sync", tx_state, 2'd1);
        step(1'b0, 1'b0, 1'b1, 32'h12345678);
        chk("recirc_directed_data", data_recirculador_inactive, 32'h12345678);
        chk("recirc_directed_valid", valid_recirculador_inactive, 1'b1);

        step(1'b1, 1'b1, 1'b0, '0);
        wait_active_load('0);
        step(1'b0, 1'b1, 1'b1, 32'hA1B2C3D4);
        for (int i = 0; i < PP; i++) begin
            cap0[15-i] = data_paralelo_serial[0];
            cap1[15-i] = data_paralelo_serial[1];
            step(1'b0, 1'b1, 1'b0, '0);
        end
        chk("lane0_word", cap0, 16'b1101010010110010);
        chk("lane1_word", cap1, 16'b1100001110100001);
        step(1'b0, 1'b1, 1'b1, 32'h12345678);
        chk("recirc_active_data", data_recirculador_inactive, '0);
        chk("recirc_active_valid", valid_recirculador_inactive, 1'b0);

        wait_active_load('0);
        step(1'b0, 1'b1, 1'b1, 32'hCAFEF00D);
        while (m_cnt != 5) step(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1, 32'h0BADF00D);
        chk("drop_active_idle", tx_state, 2'd1);

        wait_active_load('0);
        step(1'b0, 1'b1, 1'b1, 32'h55AA33CC);
        while (m_cnt != 7) step(1'b0, 1'b1, 1'b1, 32'h55AA33CC);
        step(1'b1, 1'b1, 1'b1, 32'h55AA33CC);
        chk("midreset_serial", data_paralelo_serial, '0);
        chk("midreset_state", tx_state, 2'd0);
        for (int i = 0; i < 80; i++) step(1'b0, 1'b1, 1'b0, '0);

        act_r = 1'b1;
        held = $urandom;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) act_r = !act_r;
            step(1'($urandom_range(0, 299) == 0), act_r,
                 1'($urandom_range(0, 9) < 6), held);
            if (m_consumed) held = $urandom;
        end

        running = 1'b0;
        @(negedge clk_32f);
        @(negedge clk_32f);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
